// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, 25 MHz timing defaults, frame shape.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StData,
        StAck,
        StWaitIdle,
        StDone,
        StError
    } ps2_state_e;

    // Defaults for a 25 MHz core clock.
    localparam int unsigned INHIBIT_CYCLES_DEF = 2500;    // 100 us
    localparam int unsigned RTS_CYCLES_DEF     = 25;      // 1 us
    localparam int unsigned FIRST_TIMEOUT_DEF  = 375000;  // 15 ms
    localparam int unsigned BIT_TIMEOUT_DEF    = 50000;   // 2 ms

    // Host-driven part of a frame: d0..d7, parity, stop.
    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned FRAME_FALLS = 10;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data pins plus a clock fall detector.
module ps2_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;

    // Synchroniser chains; reset to the idle (released, high) bus level so no false fall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign clk_sync = clk_sync_q;
    assign dat_sync = dat_sync_q;
    assign clk_fall = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out a byte, check the ack.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int unsigned RTS_CYCLES     = RTS_CYCLES_DEF,
    parameter int unsigned FIRST_TIMEOUT  = FIRST_TIMEOUT_DEF,
    parameter int unsigned BIT_TIMEOUT    = BIT_TIMEOUT_DEF
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned CNT_MAX =
        max2(max2(INHIBIT_CYCLES, RTS_CYCLES), max2(FIRST_TIMEOUT, BIT_TIMEOUT));
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W = $clog2(FRAME_FALLS + 1);

    ps2_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [DATA_BITS+1:0]   shreg_q, shreg_d;
    logic                   dat_oe_q, dat_oe_d;
    logic                   clk_oe_q, clk_oe_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   clk_s, dat_s, clk_fall;

    ps2_line_sync u_sync (
        .clk      (clk25),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk_i),
        .ps2_dat  (ps2_dat_i),
        .clk_sync (clk_s),
        .dat_sync (dat_s),
        .clk_fall (clk_fall)
    );

    // Next-state, counters, shift register and registered line/status outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        dat_oe_d = dat_oe_q;

        unique case (state_q)
            StIdle: begin
                if (tx_start) begin
                    shreg_d  = {1'b1, ~^tx_data, tx_data};
                    cnt_d    = CNT_W'(INHIBIT_CYCLES - 1);
                    bitcnt_d = '0;
                    state_d  = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == '0) begin
                    cnt_d    = CNT_W'(RTS_CYCLES - 1);
                    dat_oe_d = 1'b1;
                    state_d  = StRts;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRts: begin
                // Data stays low into DATA: that is the start bit.
                if (cnt_q == '0) begin
                    cnt_d    = CNT_W'(FIRST_TIMEOUT - 1);
                    bitcnt_d = '0;
                    state_d  = StData;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StData: begin
                // A fall takes priority over a simultaneous timeout.
                if (clk_fall) begin
                    dat_oe_d = ~shreg_q[0];
                    shreg_d  = {1'b0, shreg_q[DATA_BITS+1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    cnt_d    = CNT_W'(BIT_TIMEOUT - 1);
                    if (bitcnt_q == BIT_W'(FRAME_FALLS - 1)) begin
                        state_d = StAck;
                    end
                end else if (cnt_q == '0) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAck: begin
                if (clk_fall) begin
                    cnt_d   = CNT_W'(BIT_TIMEOUT - 1);
                    state_d = dat_s ? StError : StWaitIdle;
                end else if (cnt_q == '0) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWaitIdle: begin
                if (clk_s && dat_s) begin
                    state_d = StDone;
                end else if (cnt_q == '0) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone, StError: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d == StIdle || state_d == StDone || state_d == StError) begin
            dat_oe_d = 1'b0;
        end

        clk_oe_d = (state_d == StInhibit) || (state_d == StRts);
        busy_d   = (state_d != StIdle) && (state_d != StDone) && (state_d != StError);
        done_d   = (state_d == StDone);
        error_d  = (state_d == StError);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            dat_oe_q <= 1'b0;
            clk_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            dat_oe_q <= dat_oe_d;
            clk_oe_q <= clk_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
module tb_ps2_host_tx;

    // Shortened timing so the run stays small; expectations scale with these.
    localparam int INH  = 40;
    localparam int RTSC = 6;
    localparam int FTO  = 1500;
    localparam int BTO  = 500;
    localparam int HP   = 20;   // device clock half period in core cycles

    logic       clk25 = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk, dev_dat;
    logic       line_clk, line_dat;

    assign line_clk = dev_clk & ~ps2_clk_oe;
    assign line_dat = dev_dat & ~ps2_dat_oe;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int busy_at_done = 0;
    int last_fall_cyc = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTSC),
        .FIRST_TIMEOUT  (FTO),
        .BIT_TIMEOUT    (BTO)
    ) dut (
        .clk25      (clk25),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_i  (line_clk),
        .ps2_dat_i  (line_dat),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #20 clk25 = ~clk25;

    always @(posedge clk25) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk25) begin
        if (tx_done) begin
            done_cnt = done_cnt + 1;
            if (tx_busy) busy_at_done = busy_at_done + 1;
        end
        if (tx_error) err_cnt = err_cnt + 1;
    end

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    // Count cycles of inhibit (clock low only) then request-to-send (clock and data low).
    task automatic measure_host(output int inh, output int rts);
        inh = 0;
        rts = 0;
        while (ps2_clk_oe && !ps2_dat_oe && inh < 10000) begin
            inh++;
            tick();
        end
        while (ps2_clk_oe && ps2_dat_oe && rts < 10000) begin
            rts++;
            tick();
        end
    endtask

    // Device clocks nfalls falls; bit k is the line level sampled before the rise after fall k+1.
    // Fall index 10 is the ack fall, with data pulled low first when ack_low is set.
    task automatic run_device(input int nfalls, input bit ack_low, output logic [9:0] bits);
        bits = '0;
        for (int k = 0; k < nfalls; k++) begin
            repeat (HP) tick();
            if (k == 10 && ack_low) begin
                dev_dat = 1'b0;
                repeat (2) tick();
            end
            dev_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HP) tick();
            if (k < 10) bits[k] = line_dat;
            dev_clk = 1'b1;
        end
        repeat (2) tick();
        dev_dat = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (tx_busy && n < 5000) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 5000), 32'd1);
        repeat (4) tick();
    endtask

    initial begin
        int inh, rts, t0, d0, e0, n;
        logic [9:0] bits;

        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        tx_data  = 8'h00;
        tx_start = 1'b0;
        reset_n  = 1'b0;
        repeat (3) tick();
        check("reset outputs", {27'd0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 0);
        reset_n = 1'b1;
        repeat (3) tick();

        // 0xED with ack: 1,0,1,1,0,1,1,1 then parity 1, stop 1
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hED);
        check("busy after start", 32'(tx_busy), 32'd1);
        measure_host(inh, rts);
        check("inhibit cycles", inh, INH);
        check("rts cycles", rts, RTSC);
        check("start bit line", 32'(line_dat), 32'd0);
        run_device(11, 1'b1, bits);
        wait_idle("ED completes");
        check("ED frame bits", 32'(bits), 32'h3ED);
        check("ED done pulses", done_cnt - d0, 1);
        check("ED error pulses", err_cnt - e0, 0);
        check("busy low at done", busy_at_done, 0);

        // 0xF4: odd parity bit 0
        d0 = done_cnt;
        start_tx(8'hF4);
        measure_host(inh, rts);
        run_device(11, 1'b1, bits);
        wait_idle("F4 completes");
        check("F4 parity", 32'(bits[8]), 32'd0);
        check("F4 frame bits", 32'(bits), 32'h2F4);
        check("F4 done pulses", done_cnt - d0, 1);

        // 0x00: data all 0, parity 1
        start_tx(8'h00);
        measure_host(inh, rts);
        run_device(11, 1'b1, bits);
        wait_idle("00 completes");
        check("00 frame bits", 32'(bits), 32'h300);

        // Device never clocks: first-fall timeout
        e0 = err_cnt; d0 = done_cnt;
        start_tx(8'hF4);
        t0 = cyc;
        n = 0;
        while (!tx_error && n < INH + RTSC + FTO + 50) begin
            tick();
            n++;
        end
        check_range("first timeout delay", cyc - t0, INH + RTSC + FTO - 2, INH + RTSC + FTO + 2);
        tick();
        check("oe after timeout", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        check("busy after timeout", 32'(tx_busy), 32'd0);
        repeat (3) tick();
        check("first timeout error pulses", err_cnt - e0, 1);
        check("first timeout done pulses", done_cnt - d0, 0);

        // Five falls then silence: bit timeout; 3 cycles of sync/detect latency from the pin
        e0 = err_cnt;
        start_tx(8'hED);
        measure_host(inh, rts);
        run_device(5, 1'b1, bits);
        n = 0;
        while (!tx_error && n < BTO + 100) begin
            tick();
            n++;
        end
        check_range("bit timeout delay", cyc - last_fall_cyc, BTO + 1, BTO + 5);
        repeat (3) tick();
        check("bit timeout error pulses", err_cnt - e0, 1);

        // Missing ack: data left high at the ack fall
        e0 = err_cnt; d0 = done_cnt;
        start_tx(8'hED);
        measure_host(inh, rts);
        run_device(11, 1'b0, bits);
        wait_idle("nack completes");
        check("nack error pulses", err_cnt - e0, 1);
        check("nack done pulses", done_cnt - d0, 0);

        // tx_start with 0xFF while busy is ignored
        d0 = done_cnt;
        start_tx(8'hED);
        repeat (5) tick();
        start_tx(8'hFF);
        tx_data = 8'h00;
        measure_host(inh, rts);
        run_device(11, 1'b1, bits);
        wait_idle("busy start completes");
        check("ignored start frame bits", 32'(bits), 32'h3ED);
        check("ignored start done pulses", done_cnt - d0, 1);

        // Reset in the middle of DATA
        start_tx(8'hED);
        measure_host(inh, rts);
        run_device(3, 1'b1, bits);
        d0 = done_cnt; e0 = err_cnt;
        reset_n = 1'b0;
        tick();
        check("reset mid-frame lines", {29'd0, tx_busy, ps2_clk_oe, ps2_dat_oe}, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("reset mid-frame pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
